cms_ctrl_sequencer: RTL and testbench

Serialises host configuration commands onto the continuous monitoring system's control port (ctrl_addr / ctrl_wdata / ctrl_write_enable).
- Buffers commands in a small FIFO.
- Generates a write-enable strobe with guaranteed low gaps, so a posedge-triggered receiver sees one edge per command.
- Optionally gates the monitor's enable while a configuration batch is in flight.
- Sits between the PS-side control GPIO/AXI-lite glue and the monitor wrapper.

---
 rtl/cms_ctrl_pkg.sv | 21 ++
 rtl/cms_ctrl_sequencer_fifo.sv | 49 ++++
 rtl/cms_ctrl_sequencer.sv | 176 +++++++++++++++++
 tb/tb_cms_ctrl_sequencer.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cms_ctrl_pkg.sv
// Shared types for the CMS control-port sequencer:
// control widths, sequencer FSM state, buffered command record.
package cms_ctrl_pkg;

   localparam int CTRL_ADDR_WIDTH = 8;
   localparam int CTRL_DATA_WIDTH = 64;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_GAP
   } state_e;

   typedef struct packed {
      logic [CTRL_ADDR_WIDTH-1:0] addr;
      logic [CTRL_DATA_WIDTH-1:0] wdata;
      logic                       last;
   } cmd_t;

endpackage

// File: rtl/cms_ctrl_sequencer_fifo.sv
// Synchronous command FIFO (show-ahead head, occupancy count).
// Ports: push_i/cmd_i write, pop_i/head_o read, count_o occupancy.
module cms_cmd_fifo
   import cms_ctrl_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  cmd_t                       cmd_i,
   input  logic                       pop_i,
   output cmd_t                       head_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   cmd_t          mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= cmd_i;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/cms_ctrl_sequencer.sv
// Serialises host commands onto the CMS control port with a
// SETUP/STROBE/GAP write-enable shape and batch-aware enable gating.
// Ports: cmd_* host side, ctrl_* / cms_en monitor side,
// busy / fifo_count / batch_done / writes_done status.
module cms_ctrl_sequencer
   import cms_ctrl_pkg::*;
#(
   parameter int CTRL_ADDR_WIDTH = cms_ctrl_pkg::CTRL_ADDR_WIDTH,
   parameter int CTRL_DATA_WIDTH = cms_ctrl_pkg::CTRL_DATA_WIDTH,
   parameter int FIFO_DEPTH      = 8,
   parameter int STROBE_CYCLES   = 1,
   parameter int GAP_CYCLES      = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            cmd_valid,
   output logic                            cmd_ready,
   input  logic [CTRL_ADDR_WIDTH-1:0]      cmd_addr,
   input  logic [CTRL_DATA_WIDTH-1:0]      cmd_wdata,
   input  logic                            cmd_last,
   input  logic                            en_in,
   input  logic                            pause_during_cfg,
   output logic [CTRL_ADDR_WIDTH-1:0]      ctrl_addr,
   output logic [CTRL_DATA_WIDTH-1:0]      ctrl_wdata,
   output logic                            ctrl_write_enable,
   output logic                            cms_en,
   output logic                            busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
   output logic                            batch_done,
   output logic [31:0]                     writes_done
);

   localparam int CW   = $clog2(FIFO_DEPTH+1);
   localparam int TMAX = (STROBE_CYCLES > GAP_CYCLES) ?
                         STROBE_CYCLES : GAP_CYCLES;
   localparam int TW   = $clog2(TMAX+1);
   localparam logic [TW-1:0] S_END = TW'(STROBE_CYCLES-1);
   localparam logic [TW-1:0] G_END = TW'(GAP_CYCLES-1);

   state_e                     state_q, state_d;
   logic [TW-1:0]              tmr_q, tmr_d;
   logic [CTRL_ADDR_WIDTH-1:0] addr_q;
   logic [CTRL_DATA_WIDTH-1:0] wdata_q;
   logic                       last_q;
   logic                       active_q;
   logic                       done_q;
   logic                       en_q;
   logic [31:0]                writes_done_q;

   logic          push;
   logic          pop;
   logic          gap_end;
   logic          has_cmd;
   logic [CW-1:0] cnt;
   cmd_t          wr_cmd;
   cmd_t          head;

   assign cmd_ready = !rst && (cnt != CW'(FIFO_DEPTH));
   assign push      = cmd_valid && cmd_ready;
   assign has_cmd   = (cnt != '0);
   assign wr_cmd    = '{addr: cmd_addr, wdata: cmd_wdata, last: cmd_last};

   cms_cmd_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push_i (push),
      .cmd_i  (wr_cmd),
      .pop_i  (pop),
      .head_o (head),
      .count_o(cnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
      end
   end

   // GAP falls straight into SETUP when more work is queued.
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      pop     = 1'b0;
      gap_end = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (has_cmd) begin
               pop     = 1'b1;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            state_d = ST_STROBE;
            tmr_d   = '0;
         end
         ST_STROBE: begin
            if (tmr_q == S_END) begin
               state_d = ST_GAP;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         ST_GAP: begin
            if (tmr_q == G_END) begin
               gap_end = 1'b1;
               if (has_cmd) begin
                  pop     = 1'b1;
                  state_d = ST_SETUP;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ctrl_write_enable = 1'b0;
      busy              = has_cmd;
      case (state_q)
         ST_STROBE: begin
            ctrl_write_enable = 1'b1;
            busy              = 1'b1;
         end
         ST_SETUP, ST_GAP: busy = 1'b1;
         default: ;
      endcase
   end

   // A pop in the same edge as a batch end re-opens the batch (set wins).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q        <= '0;
         wdata_q       <= '0;
         last_q        <= 1'b0;
         active_q      <= 1'b0;
         done_q        <= 1'b0;
         en_q          <= 1'b0;
         writes_done_q <= '0;
      end else begin
         if (pop) begin
            addr_q  <= head.addr;
            wdata_q <= head.wdata;
            last_q  <= head.last;
         end
         if (pop) begin
            active_q <= 1'b1;
         end else if (gap_end && last_q) begin
            active_q <= 1'b0;
         end
         done_q <= gap_end && last_q;
         en_q   <= en_in && !(pause_during_cfg && active_q);
         if (state_q == ST_SETUP) begin
            writes_done_q <= writes_done_q + 32'd1;
         end
      end
   end

   assign ctrl_addr   = addr_q;
   assign ctrl_wdata  = wdata_q;
   assign cms_en      = en_q;
   assign batch_done  = done_q;
   assign writes_done = writes_done_q;
   assign fifo_count  = cnt;

endmodule

// File: tb/tb_cms_ctrl_sequencer.sv
// Self-checking bench for cms_ctrl_sequencer: scoreboard on strobes,
// timing, burst/full, wide strobe shape, pause gating, reset, wrap.
module tb_cms_ctrl_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [7:0]  cmd_addr = '0;
   logic [63:0] cmd_wdata = '0;
   logic        cmd_last = 1'b0;
   logic        en_in = 1'b1;
   logic        pause = 1'b0;
   logic [7:0]  ctrl_addr;
   logic [63:0] ctrl_wdata;
   logic        we;
   logic        cms_en;
   logic        busy;
   logic [3:0]  fifo_count;
   logic        batch_done;
   logic [31:0] writes_done;

   logic        cmd_valid2 = 1'b0;
   logic        cmd_ready2;
   logic [7:0]  cmd_addr2 = '0;
   logic [63:0] cmd_wdata2 = '0;
   logic        cmd_last2 = 1'b0;
   logic [7:0]  ctrl_addr2;
   logic [63:0] ctrl_wdata2;
   logic        we2;
   logic        cms_en2;
   logic        busy2;
   logic [3:0]  fifo_count2;
   logic        batch_done2;
   logic [31:0] writes_done2;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [7:0]  sb_a [$];
   logic [63:0] sb_d [$];
   int          rise_q [$];
   logic [7:0]  ea;
   logic [63:0] ed;
   logic        we_prev = 1'b0;
   bit          saw_full = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cms_ctrl_sequencer #(
      .FIFO_DEPTH(8), .STROBE_CYCLES(1), .GAP_CYCLES(1)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .cmd_last(cmd_last), .en_in(en_in),
      .pause_during_cfg(pause),
      .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata),
      .ctrl_write_enable(we), .cms_en(cms_en), .busy(busy),
      .fifo_count(fifo_count), .batch_done(batch_done),
      .writes_done(writes_done)
   );

   cms_ctrl_sequencer #(
      .FIFO_DEPTH(8), .STROBE_CYCLES(3), .GAP_CYCLES(2)
   ) dut2 (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
      .cmd_addr(cmd_addr2), .cmd_wdata(cmd_wdata2),
      .cmd_last(cmd_last2), .en_in(1'b1),
      .pause_during_cfg(1'b0),
      .ctrl_addr(ctrl_addr2), .ctrl_wdata(ctrl_wdata2),
      .ctrl_write_enable(we2), .cms_en(cms_en2), .busy(busy2),
      .fifo_count(fifo_count2), .batch_done(batch_done2),
      .writes_done(writes_done2)
   );

   // Strobe scoreboard and ready/count invariant for dut.
   always @(negedge clk) begin
      if (rst) begin
         sb_a.delete();
         sb_d.delete();
         we_prev = 1'b0;
      end else begin
         if (we && !we_prev) begin
            rise_q.push_back(cyc);
            checks++;
            if (sb_a.size() == 0) begin
               errors++;
               $display("FAIL stale_strobe: strobe at cycle %0d, expected none", cyc);
            end else begin
               ea = sb_a.pop_front();
               ed = sb_d.pop_front();
               if (ctrl_addr !== ea || ctrl_wdata !== ed) begin
                  errors++;
                  $display("FAIL strobe_data: addr %h data %h, expected addr %h data %h",
                           ctrl_addr, ctrl_wdata, ea, ed);
               end
            end
         end
         checks++;
         if (cmd_ready !== (fifo_count != 4'd8)) begin
            errors++;
            $display("FAIL ready_vs_count: ready %b with count %0d", cmd_ready, fifo_count);
         end
         if (fifo_count == 4'd8 && !cmd_ready) saw_full = 1'b1;
         we_prev = we;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send(input bit two, input logic [7:0] a,
                       input logic [63:0] d, input logic l,
                       output int acc);
      int n;
      n = 0;
      acc = -1;
      @(negedge clk);
      if (!two) begin
         cmd_valid = 1'b1; cmd_addr = a; cmd_wdata = d; cmd_last = l;
      end else begin
         cmd_valid2 = 1'b1; cmd_addr2 = a; cmd_wdata2 = d; cmd_last2 = l;
      end
      while (!(two ? cmd_ready2 : cmd_ready) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!(two ? cmd_ready2 : cmd_ready)) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: cmd_ready 0, expected 1");
         return;
      end
      if (!two) begin
         sb_a.push_back(a);
         sb_d.push_back(d);
      end
      @(posedge clk);
      #1;
      acc = cyc;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_valid2 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      en_in = 1'b1;
      pause = 1'b0;
      #1;
      checks++;
      if (cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready: %b, expected 0", cmd_ready);
      end
      checks++;
      if ({we, busy, batch_done, cms_en, fifo_count, writes_done,
           ctrl_addr, ctrl_wdata} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: we %b busy %b bd %b en %b cnt %0d wd %0d addr %h data %h, expected all 0",
                  we, busy, batch_done, cms_en, fifo_count, writes_done,
                  ctrl_addr, ctrl_wdata);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL release_ready: %b, expected 1", cmd_ready);
      end
      @(negedge clk);
      checks++;
      if (cms_en !== 1'b1) begin
         errors++;
         $display("FAIL release_en: cms_en %b, expected 1", cms_en);
      end
   endtask

   task automatic single_core();
      int a;
      int c;
      rise_q.delete();
      send(1'b0, 8'h05, 64'hDEAD_BEEF, 1'b1, a);
      cmd_valid = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         c = cyc;
         checks++;
         if (we !== (c == a + 2)) begin
            errors++;
            $display("FAIL single_we: cycle +%0d we %b, expected %b", c - a, we, c == a + 2);
         end
         checks++;
         if (batch_done !== (c == a + 4)) begin
            errors++;
            $display("FAIL single_bd: cycle +%0d batch_done %b, expected %b",
                     c - a, batch_done, c == a + 4);
         end
         if (c >= a + 1 && c <= a + 3) begin
            checks++;
            if (ctrl_addr !== 8'h05 || ctrl_wdata !== 64'hDEAD_BEEF) begin
               errors++;
               $display("FAIL single_hold: addr %h data %h, expected 05 deadbeef",
                        ctrl_addr, ctrl_wdata);
            end
         end
      end
      checks++;
      if (writes_done !== 32'd1 || busy !== 1'b0 || rise_q.size() != 1) begin
         errors++;
         $display("FAIL single_end: writes %0d busy %b strobes %0d, expected 1 0 1",
                  writes_done, busy, rise_q.size());
      end
   endtask

   task automatic test_single();
      do_reset();
      single_core();
   endtask

   task automatic test_burst();
      int a;
      int n;
      int fall;
      do_reset();
      rise_q.delete();
      saw_full = 1'b0;
      for (int i = 0; i < 14; i++) begin
         send(1'b0, 8'(8'h10 + i), {32'hCAFE_0000, 32'(i)}, i == 13, a);
      end
      cmd_valid = 1'b0;
      n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      fall = cyc;
      checks++;
      if (busy !== 1'b0 || rise_q.size() != 14) begin
         errors++;
         $display("FAIL burst_count: busy %b strobes %0d, expected 0 14", busy, rise_q.size());
      end else begin
         for (int i = 1; i < 14; i++) begin
            checks++;
            if (rise_q[i] - rise_q[i-1] != 3) begin
               errors++;
               $display("FAIL burst_spacing: strobe %0d gap %0d, expected 3",
                        i, rise_q[i] - rise_q[i-1]);
            end
         end
         checks++;
         if (fall != rise_q[13] + 2) begin
            errors++;
            $display("FAIL burst_busy_fall: +%0d after last strobe, expected +2",
                     fall - rise_q[13]);
         end
      end
      checks++;
      if (!saw_full || writes_done !== 32'd14 || sb_a.size() != 0) begin
         errors++;
         $display("FAIL burst_end: full_seen %b writes %0d left %0d, expected 1 14 0",
                  saw_full, writes_done, sb_a.size());
      end
   endtask

   task automatic test_wide_strobe();
      int a;
      int a2;
      int c;
      int idx;
      logic exp_we [12] = '{0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0};
      do_reset();
      send(1'b1, 8'hA1, 64'h1111, 1'b0, a);
      send(1'b1, 8'hA2, 64'h2222, 1'b1, a2);
      cmd_valid2 = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         c = cyc;
         idx = c - (a + 1);
         if (idx >= 0 && idx < 12) begin
            checks++;
            if (we2 !== exp_we[idx]) begin
               errors++;
               $display("FAIL wide_we: step %0d we %b, expected %b", idx, we2, exp_we[idx]);
            end
            if (idx >= 1 && idx <= 3 && ctrl_addr2 !== 8'hA1) begin
               errors++;
               $display("FAIL wide_addr1: %h, expected a1", ctrl_addr2);
            end
            if (idx >= 7 && idx <= 9 && ctrl_addr2 !== 8'hA2) begin
               errors++;
               $display("FAIL wide_addr2: %h, expected a2", ctrl_addr2);
            end
         end
      end
      repeat (3) @(negedge clk);
      checks++;
      if (writes_done2 !== 32'd2 || busy2 !== 1'b0) begin
         errors++;
         $display("FAIL wide_end: writes %0d busy %b, expected 2 0", writes_done2, busy2);
      end
   endtask

   task automatic test_pause(input bit p);
      int a;
      int b;
      int c;
      logic exp_en;
      pause = p;
      en_in = 1'b1;
      do_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (cms_en !== 1'b1) begin
         errors++;
         $display("FAIL pause_pre: cms_en %b, expected 1", cms_en);
      end
      send(1'b0, 8'h21, 64'h21, 1'b0, a);
      send(1'b0, 8'h22, 64'h22, 1'b0, b);
      send(1'b0, 8'h23, 64'h23, 1'b1, b);
      cmd_valid = 1'b0;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         c = cyc;
         exp_en = !(p && c >= a + 2 && c <= a + 10);
         checks++;
         if (cms_en !== exp_en) begin
            errors++;
            $display("FAIL pause_en(p=%0d): cycle +%0d cms_en %b, expected %b",
                     p, c - a, cms_en, exp_en);
         end
         checks++;
         if (batch_done !== (c == a + 10)) begin
            errors++;
            $display("FAIL pause_bd(p=%0d): cycle +%0d batch_done %b, expected %b",
                     p, c - a, batch_done, c == a + 10);
         end
      end
      pause = 1'b0;
   endtask

   task automatic test_reset_mid();
      int a;
      int n;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         send(1'b0, 8'(8'h40 + i), 64'(i), 1'b1, a);
      end
      cmd_valid = 1'b0;
      n = 0;
      while (!we && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (we !== 1'b1 || fifo_count !== 4'd4) begin
         errors++;
         $display("FAIL mid_setup: we %b count %0d, expected 1 4", we, fifo_count);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (we !== 1'b0 || fifo_count !== 4'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_drop: we %b count %0d busy %b, expected 0 0 0",
                  we, fifo_count, busy);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (batch_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_bd: batch_done %b, expected 0", batch_done);
         end
      end
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         checks++;
         if (we !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_stale: we %b busy %b, expected 0 0", we, busy);
         end
      end
      single_core();
   endtask

   task automatic test_wrap();
      int a;
      do_reset();
      @(negedge clk);
      force dut.writes_done_q = 32'hFFFF_FFFF;
      #1;
      release dut.writes_done_q;
      #1;
      checks++;
      if (writes_done !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL wrap_preload: %h, expected ffffffff", writes_done);
      end
      send(1'b0, 8'h77, 64'h77, 1'b1, a);
      cmd_valid = 1'b0;
      repeat (6) @(negedge clk);
      checks++;
      if (writes_done !== 32'd0) begin
         errors++;
         $display("FAIL wrap_value: %h, expected 0", writes_done);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_wide_strobe();
      test_pause(1'b1);
      test_pause(1'b0);
      test_reset_mid();
      test_wrap();
      checks++;
      if (sb_a.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: %0d, expected 0", sb_a.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
